test_vector_engine: RTL



---
 rtl/test_vector_engine.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/test_vector_engine.sv
// Command-driven test-vector sequencer: applies stimulus, waits a programmable settle time,
// compares the masked response and emits one result per vector. Optional: TVE_STOP_ON_FAIL_EN.
module test_vector_engine #(
    parameter int STF_WIDTH  = 24,
    parameter int RTF_WIDTH  = 24,
    parameter int CMD_WIDTH  = 3,
    parameter int WAIT_WIDTH = 16,
    parameter int DSEL_WIDTH = 5,
    parameter int CNT_WIDTH  = 16,
    parameter int IN_WIDTH   = CMD_WIDTH + STF_WIDTH + RTF_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  done,
    input  logic [IN_WIDTH-1:0]   cmd_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [STF_WIDTH-1:0]  mosi,
    input  logic [RTF_WIDTH-1:0]  miso,
    output logic [DSEL_WIDTH-1:0] target_sel,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [RTF_WIDTH-1:0]  res_data,
    output logic                  res_fail,
    output logic [CNT_WIDTH-1:0]  vec_count,
    output logic [CNT_WIDTH-1:0]  fail_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SETTLE = 3'd2,
        REPORT = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [CMD_WIDTH-1:0] OP_SET_WAIT = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] OP_SET_MASK = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] OP_TEST     = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] OP_SET_SEL  = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] OP_END      = CMD_WIDTH'(5);

    state_t                 state;
    logic [WAIT_WIDTH-1:0]  wait_reg;
    logic [WAIT_WIDTH-1:0]  settle_cnt;
    logic [RTF_WIDTH-1:0]   mask_reg;
    logic [RTF_WIDTH-1:0]   exp_reg;

    logic [CMD_WIDTH-1:0]   cmd_op;
    logic [STF_WIDTH-1:0]   cmd_stim;
    logic [RTF_WIDTH-1:0]   cmd_exp;
    logic                   vec_fail;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic masked_miss(input logic [RTF_WIDTH-1:0] resp,
                                         input logic [RTF_WIDTH-1:0] expv,
                                         input logic [RTF_WIDTH-1:0] msk);
        return |((resp ^ expv) & msk);
    endfunction

    assign cmd_op    = cmd_data[IN_WIDTH-1 -: CMD_WIDTH];
    assign cmd_stim  = cmd_data[RTF_WIDTH +: STF_WIDTH];
    assign cmd_exp   = cmd_data[RTF_WIDTH-1:0];
    assign cmd_ready = (state == FETCH) && enable;
    assign vec_fail  = masked_miss(miso, exp_reg, mask_reg);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wait_reg   <= '0;
            settle_cnt <= '0;
            mask_reg   <= '1;
            exp_reg    <= '0;
            mosi       <= '0;
            target_sel <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_fail   <= 1'b0;
            done       <= 1'b0;
            vec_count  <= '0;
            fail_count <= '0;
        end else if (!enable) begin
            // Abort: datapath registers and counters hold, any pending result is dropped
            state     <= IDLE;
            res_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    vec_count  <= '0;
                    fail_count <= '0;
                    state      <= FETCH;
                end
                FETCH: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_SET_WAIT: wait_reg <= cmd_stim[WAIT_WIDTH-1:0];
                            OP_SET_MASK: mask_reg <= cmd_exp;
                            OP_TEST: begin
                                mosi       <= cmd_stim;
                                exp_reg    <= cmd_exp;
                                settle_cnt <= wait_reg;
                                state      <= SETTLE;
                            end
                            OP_SET_SEL: target_sel <= cmd_stim[DSEL_WIDTH-1:0];
                            OP_END: begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                            default: ;
                        endcase
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        res_data  <= miso;
                        res_fail  <= vec_fail;
                        res_valid <= 1'b1;
                        vec_count <= sat_inc(vec_count);
                        if (vec_fail)
                            fail_count <= sat_inc(fail_count);
                        state <= REPORT;
                    end else begin
                        settle_cnt <= settle_cnt - WAIT_WIDTH'(1);
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
`ifdef TVE_STOP_ON_FAIL_EN
                        if (res_fail) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                        end
`else
                        state <= FETCH;
`endif
                    end
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
